// File: rtl/axp_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : axp_lsu
//  Purpose  : Load/store unit: one aligned 64-bit bus access per request,
//             load extraction/extension and LDx_L/STx_C lock tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module axp_lsu #(
    parameter int LOCK_LSB = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] cmd,
    input  logic [63:0] addr,
    input  logic [7:0]  mask,
    input  logic [63:0] st_data,
    input  logic        lock_clear,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [60:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_be,
    output logic [63:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_wb,
    output logic        res_fault,
    output logic [63:0] res_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [5:0] c_op_ldbu  = 6'h0A;
    localparam logic [5:0] c_op_ldq_u = 6'h0B;
    localparam logic [5:0] c_op_ldwu  = 6'h0C;
    localparam logic [5:0] c_op_stw   = 6'h0D;
    localparam logic [5:0] c_op_stb   = 6'h0E;
    localparam logic [5:0] c_op_stq_u = 6'h0F;
    localparam logic [5:0] c_op_ldl   = 6'h28;
    localparam logic [5:0] c_op_ldq   = 6'h29;
    localparam logic [5:0] c_op_ldl_l = 6'h2A;
    localparam logic [5:0] c_op_ldq_l = 6'h2B;
    localparam logic [5:0] c_op_stl   = 6'h2C;
    localparam logic [5:0] c_op_stq   = 6'h2D;
    localparam logic [5:0] c_op_stl_c = 6'h2E;
    localparam logic [5:0] c_op_stq_c = 6'h2F;

    state_t r_state, w_state_nxt;

    logic [5:0]           r_op;
    logic [63:0]          r_ea;
    logic [7:0]           r_be;
    logic [63:0]          r_wdata;
    logic                 r_we;
    logic                 r_is_load;
    logic                 r_is_ldl;
    logic                 r_is_stc;
    logic                 r_res_wb;
    logic                 r_res_fault;
    logic [63:0]          r_res_data;
    logic                 r_lock;
    logic [63:LOCK_LSB]   r_lock_addr;

    logic [5:0]  w_op;
    logic        w_is_load, w_is_store, w_is_ldl, w_is_stc, w_is_unal;
    logic [63:0] w_ea;
    logic [2:0]  w_szm1;
    logic        w_fault, w_gran_hit, w_stc_ok, w_accept, w_direct;
    logic [63:0] w_rd_sh, w_ld_data;
    logic        w_unused;

    assign w_op     = cmd[31:26];
    assign w_unused = ^cmd[25:0];

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_ldl   = 1'b0;
        w_is_stc   = 1'b0;
        w_is_unal  = 1'b0;
        case (w_op)
            c_op_ldbu, c_op_ldwu, c_op_ldl, c_op_ldq: w_is_load = 1'b1;
            c_op_ldq_u: begin
                w_is_load = 1'b1;
                w_is_unal = 1'b1;
            end
            c_op_ldl_l, c_op_ldq_l: begin
                w_is_load = 1'b1;
                w_is_ldl  = 1'b1;
            end
            c_op_stw, c_op_stb, c_op_stl, c_op_stq: w_is_store = 1'b1;
            c_op_stq_u: begin
                w_is_store = 1'b1;
                w_is_unal  = 1'b1;
            end
            c_op_stl_c, c_op_stq_c: begin
                w_is_store = 1'b1;
                w_is_stc   = 1'b1;
            end
            default: ;
        endcase
    end

    // Size-1 falls out of the mask's top lane bits: 01->0, 03->1, 0F->3, FF->7
    assign w_ea       = w_is_unal ? {addr[63:3], 3'b000} : addr;
    assign w_szm1     = {mask[7], mask[3], mask[1]};
    assign w_fault    = |(w_ea[2:0] & w_szm1);
    assign w_gran_hit = r_lock && (r_lock_addr == w_ea[63:LOCK_LSB]);
    assign w_stc_ok   = w_gran_hit && !lock_clear && !w_fault;
    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_direct   = w_fault || (w_is_stc && !w_stc_ok);

    assign w_rd_sh = bus_rdata >> {r_ea[2:0], 3'b000};

    always_comb begin
        case (r_op)
            c_op_ldbu:             w_ld_data = {56'd0, w_rd_sh[7:0]};
            c_op_ldwu:             w_ld_data = {48'd0, w_rd_sh[15:0]};
            c_op_ldl, c_op_ldl_l:  w_ld_data = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
            default:               w_ld_data = w_rd_sh;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = w_direct ? S_RESP : S_ISSUE;
            S_ISSUE: if (bus_ready)  w_state_nxt = S_WAIT;
            S_WAIT:  if (bus_rvalid) w_state_nxt = S_RESP;
            S_RESP:  if (res_ready)  w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_ea        <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_ldl    <= 1'b0;
            r_is_stc    <= 1'b0;
            r_res_wb    <= 1'b0;
            r_res_fault <= 1'b0;
            r_res_data  <= '0;
        end else if (w_accept) begin
            r_op        <= w_op;
            r_ea        <= w_ea;
            r_be        <= mask << w_ea[2:0];
            r_wdata     <= st_data << {w_ea[2:0], 3'b000};
            r_we        <= w_is_store;
            r_is_load   <= w_is_load;
            r_is_ldl    <= w_is_ldl;
            r_is_stc    <= w_is_stc;
            // Preloaded for the direct-to-RESP path; overwritten on bus completion
            r_res_fault <= w_fault;
            r_res_wb    <= w_is_stc && !w_fault;
            r_res_data  <= '0;
        end else if (r_state == S_WAIT && bus_rvalid) begin
            r_res_fault <= 1'b0;
            r_res_wb    <= r_is_load || r_is_stc;
            r_res_data  <= r_is_load ? w_ld_data : {63'd0, r_is_stc};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock      <= 1'b0;
            r_lock_addr <= '0;
        end else if (lock_clear) begin
            r_lock <= 1'b0;
        end else if (w_accept && (w_is_stc || (w_is_store && w_gran_hit))) begin
            r_lock <= 1'b0;
        end else if (r_state == S_WAIT && bus_rvalid && r_is_ldl) begin
            r_lock      <= 1'b1;
            r_lock_addr <= r_ea[63:LOCK_LSB];
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign bus_valid = (r_state == S_ISSUE);
    assign res_valid = (r_state == S_RESP);
    assign bus_addr  = r_ea[63:3];
    assign bus_we    = r_we;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign res_wb    = r_res_wb;
    assign res_fault = r_res_fault;
    assign res_data  = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_axp_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axp_lsu
//  Purpose  : Directed and randomized checks of axp_lsu against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axp_lsu;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] cmd = '0;
    logic [63:0] addr = '0;
    logic [7:0]  mask = '0;
    logic [63:0] st_data = '0;
    logic        lock_clear = 1'b0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [60:0] bus_addr;
    logic        bus_we;
    logic [7:0]  bus_be;
    logic [63:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [63:0] bus_rdata = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_wb;
    logic        res_fault;
    logic [63:0] res_data;

    int n_checks = 0;
    int n_pass   = 0;

    // reference lock state, granule = 8 bytes
    bit          m_lock = 1'b0;
    logic [63:0] m_gran = '0;

    axp_lsu #(.LOCK_LSB(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .cmd(cmd), .addr(addr), .mask(mask), .st_data(st_data),
        .lock_clear(lock_clear),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_wb(res_wb),
        .res_fault(res_fault), .res_data(res_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [7:0] mask_of(input logic [5:0] op);
        case (op)
            6'h0A, 6'h0E:               return 8'h01;
            6'h0C, 6'h0D:               return 8'h03;
            6'h28, 6'h2A, 6'h2C, 6'h2E: return 8'h0F;
            default:                    return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] load_val(input logic [5:0] op, input logic [63:0] rd, input int sh);
        logic [63:0] d;
        d = rd >> (8 * sh);
        case (op)
            6'h0A:        return d & 64'hFF;
            6'h0C:        return d & 64'hFFFF;
            6'h28, 6'h2A: return {{32{d[31]}}, d[31:0]};
            default:      return d;
        endcase
    endfunction

    task automatic do_op(input logic [5:0] op, input logic [63:0] a, input logic [63:0] sd,
                         input logic [63:0] rd, input bit lc, input int bdly,
                         input int rdly, input int hold);
        logic [7:0]  m, e_be;
        logic [63:0] ea, e_wdata, e_data;
        int          sh, size;
        bit          is_load, is_stc, is_ldl, fault, ok, direct, e_wb;

        m       = mask_of(op);
        ea      = (op == 6'h0B || op == 6'h0F) ? (a & ~64'h7) : a;
        sh      = int'(ea[2:0]);
        size    = $countones(m);
        fault   = (ea % size) != 0;
        is_load = op inside {6'h0A, 6'h0B, 6'h0C, 6'h28, 6'h29, 6'h2A, 6'h2B};
        is_stc  = op inside {6'h2E, 6'h2F};
        is_ldl  = op inside {6'h2A, 6'h2B};
        e_be    = m << sh;
        e_wdata = sd << (8 * sh);

        if (lc) m_lock = 1'b0;
        ok = 1'b0;
        if (is_stc) begin
            ok     = m_lock && ((ea >> 3) == m_gran) && !fault;
            m_lock = 1'b0;
        end else if (!is_load && m_lock && ((ea >> 3) == m_gran)) begin
            m_lock = 1'b0;
        end
        direct = fault || (is_stc && !ok);

        if (fault)        begin e_wb = 0; e_data = 0; end
        else if (is_stc)  begin e_wb = 1; e_data = {63'd0, ok}; end
        else if (is_load) begin e_wb = 1; e_data = load_val(op, rd, sh); end
        else              begin e_wb = 0; e_data = 0; end

        @(negedge clock);
        check("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        cmd        = {op, 26'($urandom)};
        addr       = a;
        mask       = m;
        st_data    = sd;
        lock_clear = lc;
        @(negedge clock);
        req_valid  = 1'b0;
        lock_clear = 1'b0;
        cmd        = '0;
        addr       = 64'($urandom);

        if (direct) begin
            check("direct_bus_valid", bus_valid, 0);
        end else begin
            for (int i = 0; i <= bdly; i++) begin
                check("bus_valid", bus_valid, 1);
                check("bus_addr", bus_addr, ea >> 3);
                check("bus_we", bus_we, !is_load);
                check("bus_be", bus_be, e_be);
                if (!is_load) check("bus_wdata", bus_wdata, e_wdata);
                check("res_valid_early", res_valid, 0);
                if (i == bdly) bus_ready = 1'b1;
                else if (i == 0) bus_rvalid = 1'b1;
                @(negedge clock);
                bus_ready  = 1'b0;
                bus_rvalid = 1'b0;
            end
            for (int i = 0; i <= rdly; i++) begin
                check("wait_bus_valid", bus_valid, 0);
                check("wait_res_valid", res_valid, 0);
                if (i == rdly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd;
                end
                @(negedge clock);
                bus_rvalid = 1'b0;
                bus_rdata  = {$urandom, $urandom};
            end
            if (is_ldl) begin
                m_lock = 1'b1;
                m_gran = ea >> 3;
            end
        end

        for (int i = 0; i <= hold; i++) begin
            check("res_valid", res_valid, 1);
            check("req_ready_resp", req_ready, 0);
            check("res_fault", res_fault, fault);
            check("res_wb", res_wb, e_wb);
            check("res_data", res_data, e_data);
            if (i == hold) res_ready = 1'b1;
            @(negedge clock);
            res_ready = 1'b0;
        end
        check("res_valid_drop", res_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic [5:0] ops [14] = '{6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h28,
                                 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h2F};

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_res_data", res_data, 0);
        @(negedge clock);
        reset_n = 1'b1;

        do_op(6'h0A, 64'h1003, 0, 64'h8877665544332211, 0, 0, 0, 0);
        do_op(6'h28, 64'h1004, 0, 64'h8000000100000000, 0, 0, 0, 1);
        do_op(6'h0D, 64'h2006, 64'hABCD, 0, 0, 1, 0, 0);
        do_op(6'h29, 64'h1004, 0, 0, 0, 0, 0, 0);
        do_op(6'h2B, 64'h3000, 0, 64'h1122334455667788, 0, 0, 0, 0);
        do_op(6'h2F, 64'h3000, 64'h5555, 0, 0, 0, 1, 0);
        do_op(6'h2F, 64'h3000, 64'h5555, 0, 0, 0, 0, 0);
        do_op(6'h0B, 64'h1007, 0, 64'hCAFEF00DDEADBEEF, 0, 5, 2, 2);
        do_op(6'h2A, 64'h3004, 0, 64'hFFFFFFFF00000000, 0, 0, 0, 0);
        do_op(6'h2C, 64'h3000, 64'h1, 0, 0, 0, 0, 0);
        do_op(6'h2E, 64'h3004, 64'h2, 0, 0, 0, 0, 0);
        do_op(6'h2B, 64'h3000, 0, 0, 0, 0, 0, 0);
        do_op(6'h2F, 64'h3000, 64'h3, 0, 1, 0, 0, 0);

        // reset while waiting for read data, then a stray late bus_rvalid
        do_op(6'h2B, 64'h3000, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        req_valid = 1'b1;
        cmd       = {6'h29, 26'd0};
        addr      = 64'h5000;
        mask      = 8'hFF;
        @(negedge clock);
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(negedge clock);
        bus_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rstw_req_ready", req_ready, 1);
        check("rstw_res_valid", res_valid, 0);
        check("rstw_bus_valid", bus_valid, 0);
        m_lock = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus_rvalid = 1'b1;
        @(negedge clock);
        bus_rvalid = 1'b0;
        @(negedge clock);
        check("late_rvalid_res", res_valid, 0);
        check("late_rvalid_idle", req_ready, 1);
        do_op(6'h2F, 64'h3000, 64'h7, 0, 0, 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            do_op(ops[$urandom_range(0, 13)],
                  64'h4000 + 64'($urandom_range(0, 31)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
